// File: rtl/sevenseg_scroller.sv
// Loads an ASCII message through a valid/ready port, then scrolls it right-to-left
// across four ASCII digit outputs, followed by four blank positions before wrapping.
module sevenseg_scroller #(
  parameter int MSG_DEPTH  = 16,
  parameter int SCROLL_DIV = 25000000,
  parameter int DIV_W      = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hold,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       scrolling,
  output logic [7:0] display_0,
  output logic [7:0] display_1,
  output logic [7:0] display_2,
  output logic [7:0] display_3
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  // Wide enough for pos + 3 + 3, the largest un-wrapped window index.
  localparam int CW = $clog2(MSG_DEPTH + 8);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(MSG_DEPTH);
  localparam logic [DIV_W-1:0] TICK_MAX = DIV_W'(SCROLL_DIV - 1);
  localparam logic [7:0]       SPACE    = 8'h20;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

  state_t           state, state_next;
  logic [7:0]       msg [MSG_DEPTH];
  logic [CW-1:0]    len, pos, len_inc, last_pos;
  logic [DIV_W-1:0] tick;
  logic             accept, enter;

  assign wr_ready  = (state != SCROLL) && (len < DEPTH_C);
  assign accept    = wr_valid && wr_ready;
  assign len_inc   = len + CW'(1);
  assign last_pos  = len + CW'(3);
  assign scrolling = (state == SCROLL);
  assign enter     = (state_next == SCROLL) && (state != SCROLL);

  // Character at window slot k of the virtual sequence: message then four spaces.
  function automatic logic [7:0] win_char(input logic [CW-1:0] p, input int k);
    logic [CW-1:0] idx, wrap;
    wrap = len + CW'(4);
    idx  = p + CW'(k);
    if (idx >= wrap) idx = idx - wrap;
    win_char = (idx < len) ? msg[idx[AW-1:0]] : SPACE;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE, LOAD: begin
        if (accept) state_next = (wr_last || len_inc == DEPTH_C) ? SCROLL : LOAD;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      len   <= '0;
      pos   <= '0;
      tick  <= '0;
    end else begin
      state <= state_next;
      if (accept) len <= len_inc;
      if (enter) begin
        pos  <= '0;
        tick <= '0;
      end else if (state == SCROLL && !hold) begin
        if (tick == TICK_MAX) begin
          tick <= '0;
          pos  <= (pos == last_pos) ? '0 : pos + CW'(1);
        end else begin
          tick <= tick + DIV_W'(1);
        end
      end
    end
  end

  // Message storage is data only; a flush simply resets len.
  always_ff @(posedge clk) begin
    if (accept && !rst && !clear) msg[len[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear || state != SCROLL) begin
      display_0 <= SPACE;
      display_1 <= SPACE;
      display_2 <= SPACE;
      display_3 <= SPACE;
    end else begin
      display_0 <= win_char(pos, 0);
      display_1 <= win_char(pos, 1);
      display_2 <= win_char(pos, 2);
      display_3 <= win_char(pos, 3);
    end
  end

endmodule

// File: tb/tb_sevenseg_scroller.sv
// Bench for sevenseg_scroller: a 16-deep and a 4-deep instance, both stepping every 4 clocks.
module tb_sevenseg_scroller;

  logic       clk = 1'b0;
  logic       rst, clear, hold, wr_valid, wr_last, sel;
  logic [7:0] wr_data;

  logic       ready_a, ready_b, scr_a, scr_b;
  logic [7:0] d0_a, d1_a, d2_a, d3_a, d0_b, d1_b, d2_b, d3_b;
  logic       valid_a, valid_b, ready, scrolling;
  logic [31:0] win;

  always #5 clk = ~clk;

  assign valid_a   = wr_valid && !sel;
  assign valid_b   = wr_valid && sel;
  assign ready     = sel ? ready_b : ready_a;
  assign scrolling = sel ? scr_b : scr_a;
  assign win       = sel ? {d0_b, d1_b, d2_b, d3_b} : {d0_a, d1_a, d2_a, d3_a};

  sevenseg_scroller #(.MSG_DEPTH(16), .SCROLL_DIV(4), .DIV_W(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .hold(hold),
    .wr_valid(valid_a), .wr_ready(ready_a), .wr_data(wr_data), .wr_last(wr_last),
    .scrolling(scr_a),
    .display_0(d0_a), .display_1(d1_a), .display_2(d2_a), .display_3(d3_a)
  );

  sevenseg_scroller #(.MSG_DEPTH(4), .SCROLL_DIV(4), .DIV_W(3)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .hold(hold),
    .wr_valid(valid_b), .wr_ready(ready_b), .wr_data(wr_data), .wr_last(wr_last),
    .scrolling(scr_b),
    .display_0(d0_b), .display_1(d1_b), .display_2(d2_b), .display_3(d3_b)
  );

  typedef struct {
    int          id;
    logic [31:0] win;
  } row_t;

  row_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [31:0] exp);
    n_tests++;
    if (win !== exp) begin
      n_fail++;
      $display("FAIL %s: window got \"%s\" (%h), expected \"%s\"", name, win, win, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input int id, input logic [31:0] w);
    row_t r;
    r.id  = id;
    r.win = w;
    tbl.push_back(r);
  endtask

  task automatic push_exp(input int id);
    foreach (tbl[i]) if (tbl[i].id == id) exp_q.push_back(tbl[i].win);
  endtask

  // Leaves the bench at the negedge right after the SCROLL-entry edge.
  task automatic load(input string s, input bit with_last);
    for (int i = 0; i < s.len(); i++) begin
      wr_valid = 1'b1;
      wr_data  = s[i];
      wr_last  = with_last && (i == s.len() - 1);
      cyc(1);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    for (int i = 0; i < 20 && !scrolling; i++) cyc(1);
    chk("scroll_entry", {31'd0, scrolling}, 32'd1);
  endtask

  task automatic run_windows(input string name);
    logic [31:0] e;
    cyc(1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_win(name, e);
      if (exp_q.size() > 0) cyc(4);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    add(0, "HELL"); add(0, "ELLO"); add(0, "LLO "); add(0, "LO  "); add(0, "O   ");
    add(0, "    "); add(0, "   H"); add(0, "  HE"); add(0, " HEL"); add(0, "HELL");
    add(1, "7   "); add(1, "    "); add(1, "   7"); add(1, "  7 "); add(1, " 7  ");
    add(1, "7   ");
    add(2, "ABCD"); add(2, "BCD "); add(2, "CD  "); add(2, "D   "); add(2, "    ");
    add(2, "   A"); add(2, "  AB"); add(2, " ABC"); add(2, "ABCD");

    rst = 1'b1; clear = 1'b0; hold = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wr_data = 8'h00; sel = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_scrolling", {31'd0, scrolling}, 32'd0);
    chk_win("rst_display", "    ");
    sel = 1'b1;
    chk("rst_ready_d4", {31'd0, ready}, 32'd1);
    chk_win("rst_display_d4", "    ");
    sel = 1'b0;

    // HELLO full scroll period
    load("HELLO", 1'b1);
    chk("hello_ready_low", {31'd0, ready}, 32'd0);
    chk_win("hello_entry_blank", "    ");
    push_exp(0);
    run_windows("hello");

    // Clear with a simultaneous write of 'X'
    clear = 1'b1; wr_valid = 1'b1; wr_data = "X";
    cyc(1);
    clear = 1'b0; wr_valid = 1'b0;
    chk("clear_scrolling", {31'd0, scrolling}, 32'd0);
    chk("clear_ready", {31'd0, ready}, 32'd1);
    chk_win("clear_display", "    ");
    load("Z", 1'b1);
    cyc(1);
    chk_win("after_clear_z", "Z   ");

    // Hold during "ELLO" one tick after the step
    do_clear();
    load("HELLO", 1'b1);
    cyc(1);
    chk_win("hold_pre", "HELL");
    cyc(4);
    chk_win("hold_pre2", "ELLO");
    hold = 1'b1;
    cyc(10);
    chk_win("hold_frozen", "ELLO");
    hold = 1'b0;
    cyc(3);
    chk_win("hold_release_3", "ELLO");
    cyc(1);
    chk_win("hold_release_4", "LLO ");

    // Single character, 5-step period
    do_clear();
    load("7", 1'b1);
    push_exp(1);
    run_windows("seven");

    // Full 4-deep buffer without wr_last, extra write ignored
    sel = 1'b1;
    do_clear();
    load("ABCD", 1'b0);
    chk("fill_ready_low", {31'd0, ready}, 32'd0);
    wr_valid = 1'b1; wr_data = "E"; wr_last = 1'b1;
    push_exp(2);
    run_windows("fill");
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("fill_still_scrolling", {31'd0, scrolling}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
